// File: rtl/imem_arbiter_if.sv
// Bus bundle for the instruction-memory arbiter: fetch port, loader port
// and the shared synchronous-read memory port.
//
// Handshake rule for both request ports: a request is transferred in the
// cycle where valid=1 and ready=1. While valid=1 and ready=0 the requester
// holds addr/we/wdata stable. Responses have no backpressure. A response
// pulses rsp_valid for exactly one cycle, one cycle after the transfer.
interface imem_arbiter_if #(
  parameter int AW = 10
);
  // fetch port (read-only)
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_req_addr;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;

  // loader / debug port (read/write)
  logic          l_req_valid;
  logic          l_req_ready;
  logic          l_req_we;
  logic [31:0]   l_req_addr;
  logic [31:0]   l_req_wdata;
  logic          l_lock;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;

  // memory port
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  // arbiter side
  modport slave (
    input  f_req_valid, f_req_addr,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_lock,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  // requester / memory side
  modport master (
    output f_req_valid, f_req_addr,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_valid, l_req_we, l_req_addr, l_req_wdata, l_lock,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Two-requester round-robin arbiter in front of a word-organised,
// synchronous-read instruction memory. Grants are combinational; one
// registered stage remembers who owns the access so the response can be
// routed back exactly one cycle later.
//
// dbg_state_o = {last_q, p_valid_q, p_owner_q, p_err_q, p_we_q}
//   last_q    : 0 = fetch was granted last, 1 = loader was granted last
//   p_valid_q : a response is due this cycle
//   p_owner_q : 0 = fetch owns it, 1 = loader owns it
//   p_err_q   : the pending response is an address error
//   p_we_q    : the pending response is for a write
module imem_arbiter #(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  imem_arbiter_if.slave     bus,
  output logic [4:0]        dbg_state_o
);

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_e;

  // round-robin pointer (the arbiter's only FSM state)
  owner_e        last_q, last_d;

  // grant decisions for this cycle
  logic          f_elig, l_elig;
  logic          gnt_f, gnt_l, gnt_any;

  // selected request
  logic [31:0]   sel_addr;
  logic          sel_we;
  logic [31:0]   sel_wdata;
  logic          sel_err;
  logic [AW-1:0] sel_idx;

  // response pipeline stage
  logic          p_valid_q, p_valid_d;
  owner_e        p_owner_q, p_owner_d;
  logic          p_err_q,   p_err_d;
  logic          p_we_q,    p_we_d;

  // A byte address is usable only if word aligned and inside the 2^AW-word
  // array. Shifting instead of slicing keeps this legal for any AW.
  function automatic logic addr_err(input logic [31:0] a);
    addr_err = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  // Round-robin pointer register; reset leaves fetch as the tie winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_L;
    end else begin
      last_q <= last_d;
    end
  end

  // Next pointer: follows whichever side completed a handshake.
  always_comb begin
    last_d = last_q;
    if (gnt_f) begin
      last_d = OWN_F;
    end else if (gnt_l) begin
      last_d = OWN_L;
    end
  end

  // Grant outputs: eligibility screen, then round-robin on a tie.
  // Reset blocks both grants so nothing reaches memory while rst is high.
  always_comb begin
    f_elig = bus.f_req_valid & ~bus.l_lock & ~rst;
    l_elig = bus.l_req_valid & ~rst;
    gnt_f  = 1'b0;
    gnt_l  = 1'b0;
    if (f_elig && l_elig) begin
      if (last_q == OWN_L) begin
        gnt_f = 1'b1;
      end else begin
        gnt_l = 1'b1;
      end
    end else if (f_elig) begin
      gnt_f = 1'b1;
    end else if (l_elig) begin
      gnt_l = 1'b1;
    end
  end

  assign gnt_any         = gnt_f | gnt_l;
  assign bus.f_req_ready = gnt_f;
  assign bus.l_req_ready = gnt_l;

  // Request mux: pick the granted side's address and write fields.
  always_comb begin
    sel_addr  = 32'd0;
    sel_we    = 1'b0;
    sel_wdata = 32'd0;
    if (gnt_l) begin
      sel_addr  = bus.l_req_addr;
      sel_we    = bus.l_req_we;
      sel_wdata = bus.l_req_wdata;
    end else if (gnt_f) begin
      sel_addr  = bus.f_req_addr;
    end
    sel_err = addr_err(sel_addr);
    sel_idx = sel_addr[AW+1:2];
  end

  // Memory port: driven only for a clean grant, all-zero otherwise so an
  // errored request can never touch the array.
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = 32'd0;
    if (gnt_any && !sel_err) begin
      bus.m_en    = 1'b1;
      bus.m_we    = sel_we;
      bus.m_addr  = sel_idx;
      bus.m_wdata = sel_wdata;
    end
  end

  // Next pipeline contents: captured every cycle, empty when nothing granted.
  always_comb begin
    p_valid_d = gnt_any;
    p_owner_d = gnt_l ? OWN_L : OWN_F;
    p_err_d   = gnt_any & sel_err;
    p_we_d    = gnt_any & ~sel_err & sel_we;
  end

  // Pipeline register; an async reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_owner_q <= OWN_F;
      p_err_q   <= 1'b0;
      p_we_q    <= 1'b0;
    end else begin
      p_valid_q <= p_valid_d;
      p_owner_q <= p_owner_d;
      p_err_q   <= p_err_d;
      p_we_q    <= p_we_d;
    end
  end

  // Response routing: only reads carry memory data, everything else is 0.
  always_comb begin
    logic        rsp_is_read;
    logic [31:0] rsp_data;
    rsp_is_read     = p_valid_q & ~p_err_q & ~p_we_q;
    rsp_data        = rsp_is_read ? bus.m_rdata : 32'd0;
    bus.f_rsp_valid = p_valid_q & (p_owner_q == OWN_F);
    bus.l_rsp_valid = p_valid_q & (p_owner_q == OWN_L);
    bus.f_rsp_data  = bus.f_rsp_valid ? rsp_data : 32'd0;
    bus.l_rsp_data  = bus.l_rsp_valid ? rsp_data : 32'd0;
    bus.f_rsp_err   = bus.f_rsp_valid & p_err_q;
    bus.l_rsp_err   = bus.l_rsp_valid & p_err_q;
  end

  // Debug view of all state bits.
  assign dbg_state_o = {last_q, p_valid_q, p_owner_q, p_err_q, p_we_q};

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;
  localparam int PRE   = 64;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) bus ();
  logic [4:0] dbg_state;

  imem_arbiter #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ------------------------------------------------ synchronous-read memory
  logic [31:0] mem [WORDS];
  logic        pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [31:0] pl_data = 32'd0;

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr];
    end
  end

  // ------------------------------------------------------- reference model
  // Entry per cycle: [34]=response due, [33]=owner is loader, [32]=err, [31:0]=data
  logic [34:0] exp_q[$];
  logic [31:0] ref_mem [WORDS];
  int          m_last;   // 0 = fetch granted last, 1 = loader

  int n_checks = 0;
  int n_pass   = 0;

  // observations from the most recent step
  logic        obs_f_ready, obs_l_ready, obs_m_en;
  logic [31:0] obs_f_data, obs_l_data;
  logic        obs_f_err, obs_l_err, obs_f_valid, obs_l_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * WORDS));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % WORDS);
  endfunction

  // One cycle: drive at the falling edge, check just after, model the grant.
  task automatic step(input logic fv, input logic [31:0] fa,
                      input logic lv, input logic lwe, input logic [31:0] la,
                      input logic [31:0] lwd, input logic lk);
    logic [34:0] e;
    logic fe, le, gf, gl, err, we_exp;
    logic [31:0] a, rd;
    int idx;
    @(negedge clk);
    bus.f_req_valid = fv;  bus.f_req_addr  = fa;
    bus.l_req_valid = lv;  bus.l_req_we    = lwe;
    bus.l_req_addr  = la;  bus.l_req_wdata = lwd;
    bus.l_lock      = lk;
    #1;
    // response owed from the previous cycle
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 35'd0;
    obs_f_valid = bus.f_rsp_valid; obs_l_valid = bus.l_rsp_valid;
    obs_f_data  = bus.f_rsp_data;  obs_l_data  = bus.l_rsp_data;
    obs_f_err   = bus.f_rsp_err;   obs_l_err   = bus.l_rsp_err;
    chk("f_rsp_valid", 32'(bus.f_rsp_valid), 32'(e[34] & ~e[33]));
    chk("l_rsp_valid", 32'(bus.l_rsp_valid), 32'(e[34] & e[33]));
    chk("f_rsp_data", bus.f_rsp_data, (e[34] && !e[33]) ? e[31:0] : 32'd0);
    chk("l_rsp_data", bus.l_rsp_data, (e[34] && e[33]) ? e[31:0] : 32'd0);
    chk("f_rsp_err", 32'(bus.f_rsp_err), 32'(e[34] & ~e[33] & e[32]));
    chk("l_rsp_err", 32'(bus.l_rsp_err), 32'(e[34] & e[33] & e[32]));
    // grant by the rules: eligible sides, tie goes to the one not served last
    fe = fv && !lk;
    le = lv;
    gf = fe && (!le || m_last == 1);
    gl = le && (!fe || m_last == 0);
    obs_f_ready = bus.f_req_ready; obs_l_ready = bus.l_req_ready; obs_m_en = bus.m_en;
    chk("f_req_ready", 32'(bus.f_req_ready), 32'(gf));
    chk("l_req_ready", 32'(bus.l_req_ready), 32'(gl));
    a      = gl ? la : fa;
    err    = model_err(a);
    idx    = model_idx(a);
    we_exp = gl && lwe;
    chk("m_en", 32'(bus.m_en), 32'((gf || gl) && !err));
    chk("m_we", 32'(bus.m_we), 32'((gf || gl) && !err && we_exp));
    chk("m_addr", 32'(bus.m_addr), ((gf || gl) && !err) ? 32'(idx) : 32'd0);
    chk("m_wdata", bus.m_wdata, (gl && !err) ? lwd : 32'd0);
    // expected response and memory effect
    if (gf || gl) begin
      rd = (err || we_exp) ? 32'd0 : ref_mem[idx];
      exp_q.push_back({1'b1, gl, err, rd});
      if (!err && we_exp) ref_mem[idx] = lwd;
      m_last = gl ? 1 : 0;
    end else begin
      exp_q.push_back(35'd0);
    end
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 32'($urandom_range(0, PRE - 1)) * 4;
    else if (r == 7) return 32'($urandom_range(0, PRE - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (r == 8) return 32'h1000 + 32'($urandom_range(0, 255)) * 4;
    else             return $urandom() | 32'h0001_0000;
  endfunction

  // ---------------------------------------------------------------- sequence
  initial begin
    logic        fv_h, lv_h, lwe_h, lk_h;
    logic [31:0] fa_h, la_h, lwd_h;
    logic        f_tie;
    bus.f_req_valid = 1'b0; bus.f_req_addr  = 32'd0;
    bus.l_req_valid = 1'b0; bus.l_req_we    = 1'b0;
    bus.l_req_addr  = 32'd0; bus.l_req_wdata = 32'd0;
    bus.l_lock      = 1'b0;
    m_last = 1;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;

    // preload the low region while held in reset
    for (int i = 0; i < PRE; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : $urandom();
      @(negedge clk);
      pl_we = 1'b1; pl_addr = AW'(i); pl_data = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    pl_we = 1'b0;
    #1;
    chk("rst_f_ready", 32'(bus.f_req_ready), 32'd0);
    chk("rst_m_en", 32'(bus.m_en), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'b1_0000);
    rst = 1'b0;

    // fetch three consecutive words
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("fetch0_data", obs_f_data, 32'h11);
    step(1'b1, 32'h8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("fetch1_data", obs_f_data, 32'h22);
    idle();
    chk("fetch2_data", obs_f_data, 32'h33);

    // program-load mode: lock rises with fetch valid, loader write then read
    step(1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1);
    chk("lock_no_fetch", 32'(obs_f_ready), 32'd0);
    step(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'd0, 1'b1);
    chk("wr_rsp_valid", 32'(obs_l_valid), 32'd1);
    chk("wr_rsp_data", obs_l_data, 32'd0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    chk("rd_after_wr", obs_l_data, 32'hDEADBEEF);
    chk("lock_no_fetch2", 32'(obs_f_ready), 32'd0);

    // misaligned / out-of-range screening
    step(1'b1, 32'h6, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("misal_m_en", 32'(obs_m_en), 32'd0);
    step(1'b1, 32'h1000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("misal_err", 32'(obs_f_err), 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h42, 32'h12345678, 1'b0);
    chk("oor_err", 32'(obs_f_err), 32'd1);
    chk("oor_data", obs_f_data, 32'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h40, 32'd0, 1'b0);
    idle();
    chk("mem_unchanged", obs_l_data, 32'hDEADBEEF);

    // reset in the cycle after an accepted loader read
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.f_req_valid = 1'b1;
    #1;
    chk("rst_drop_l_valid", 32'(bus.l_rsp_valid), 32'd0);
    chk("rst_drop_l_data", bus.l_rsp_data, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_l_ready", 32'(bus.l_req_ready), 32'd0);
    chk("rst_f_ready2", 32'(bus.f_req_ready), 32'd0);
    chk("rst_m_en2", 32'(bus.m_en), 32'd0);
    bus.f_req_valid = 1'b0;
    bus.l_req_valid = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    m_last = 1;

    // both requesters valid continuously: F,L,F,L...
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
      f_tie = (k % 2 == 0);
      chk("alt_grant", 32'(obs_f_ready), 32'(f_tie));
    end
    idle();

    // randomized traffic; unaccepted requests are held stable
    fv_h = 1'b0; lv_h = 1'b0; lwe_h = 1'b0; lk_h = 1'b0;
    fa_h = 32'd0; la_h = 32'd0; lwd_h = 32'd0;
    for (int k = 0; k < 400; k++) begin
      if (!(fv_h && !obs_f_ready)) begin
        fv_h = ($urandom_range(0, 3) != 0);
        fa_h = rand_addr();
      end
      if (!(lv_h && !obs_l_ready)) begin
        lv_h  = ($urandom_range(0, 2) != 0);
        lwe_h = $urandom_range(0, 1) != 0;
        la_h  = rand_addr();
        lwd_h = $urandom();
      end
      lk_h = ($urandom_range(0, 7) == 0);
      step(fv_h, fa_h, lv_h, lwe_h, la_h, lwd_h, lk_h);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer for the word-organised instruction memory. It shares one memory port between the fetch unit (read-only) and the program loader/debug port (read/write). It translates byte addresses to word indices, screens misaligned and out-of-range accesses, and returns one response per accepted request, one cycle later. It sits between the fetch stage / loader and a synchronous-read instruction memory array.

## Interface
- AW, 10, word-address width; the memory holds 2^AW 32-bit words (default 1024 words = 4 KiB)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- f_req_valid  in  1  fetch request valid
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  32  fetch byte address
- f_rsp_valid  out  1  fetch response valid (one cycle, no backpressure)
- f_rsp_data  out  32  fetched word
- f_rsp_err  out  1  fetch address misaligned or out of range
- l_req_valid  in  1  loader request valid
- l_req_ready  out  1  loader request accepted this cycle
- l_req_we  in  1  1 = write, 0 = read
- l_req_addr  in  32  loader byte address
- l_req_wdata  in  32  loader write data
- l_lock  in  1  while 1, fetch is never granted (program-load mode)
- l_rsp_valid  out  1  loader response valid (one cycle, no backpressure)
- l_rsp_data  out  32  read data; 0 for writes and errors
- l_rsp_err  out  1  loader address misaligned or out of range
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  AW  memory word index
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after a read with m_en=1

## Operation
- Grant is combinational from the current valids, l_lock and the round-robin pointer `last`. At most one of f_req_ready / l_req_ready is 1 in any cycle.
- Fetch is eligible when f_req_valid=1 and l_lock=0. Loader is eligible when l_req_valid=1.
- One eligible requester: it is granted. Both eligible: the one not equal to `last` is granted.
- `last` updates to the granted requester at each accepted handshake (valid & ready). Reset value of `last` = loader, so fetch wins the first tie.
- Word index = addr[AW+1:2].
- Error if addr[1:0] != 0 or addr[31:AW+2] != 0. An errored request is still accepted, but m_en stays 0 (no memory access, no write).
- Non-error grant drives:
  - m_en=1
  - m_we = l_req_we for the loader, 0 for fetch
  - m_addr = word index
  - m_wdata = l_req_wdata for the loader, 0 otherwise
- No grant or error grant: m_en=0, m_we=0, m_addr=0, m_wdata=0.
- A registered pipeline stage holds the owner, the error bit and the read/write type of the cycle-N grant.
- In cycle N+1 the owner's rsp_valid=1.
  - Read: data = m_rdata, err=0.
  - Write: data=0, err=0.
  - Error: data=0, err=1.
- The non-owner's rsp_valid is 0. rsp_data and rsp_err are 0 whenever the matching rsp_valid=0.
- Back-to-back grants are allowed every cycle. A request in N and a response in N+1 may overlap with a new grant in N+1.
- Requests with valid=1 and ready=0 must be held stable by the requester. The arbiter does not latch them.

## Timing
- Reset (asynchronous assert) clears, immediately:
  - the pipeline stage
  - f_rsp_valid, l_rsp_valid, rsp_data, rsp_err to 0
  - `last` to loader
- While rst=1 no grant: both ready=0, m_en=0.
- Reset between an accepted request (cycle N) and its response: the response is dropped, not replayed.
- Request-to-response latency is exactly 1 cycle. Throughput is 1 access per cycle in aggregate.
- l_lock rising in the same cycle as f_req_valid: fetch is not granted that cycle.
- A fetch response already in flight still completes in the next cycle.
- Loader write followed next cycle by a loader read of the same word returns the new data, given the memory's write-then-read ordering.

## Test plan
- Reset, then fetch reads 0x0, 0x4, 0x8 on consecutive cycles with the memory preloaded with 0x11,0x22,0x33 -> f_req_ready=1 each cycle; f_rsp_valid on the following cycles with data 0x11,0x22,0x33, err=0.
- Both requesters valid continuously (fetch 0x10, loader read 0x20) -> grants alternate F,L,F,L starting with fetch after reset; each response lands on the correct side 1 cycle later.
- l_lock=1, loader writes 0xDEADBEEF to 0x40, then reads 0x40 while fetch stays valid -> fetch never ready; write response err=0 data=0; read response data 0xDEADBEEF.
- Fetch addr 0x6 (misaligned) and 0x1000 (AW=10, out of range) -> accepted, m_en=0, f_rsp_valid=1, err=1, data=0; the memory is unchanged.
- Assert rst in the cycle after a loader read is accepted -> l_rsp_valid stays 0, outputs go to 0 asynchronously, and fetch wins the first tie after release.
